mem_stage_ctrl: RTL and testbench

//   Consumer end of the EX/MEM pipeline register: MEM stage of the 5-stage MIPS pipeline.
//   - Issues loads/stores to a variable-latency data memory over a req/ack handshake.
//   - Stalls upstream stages until the access completes.
//   - Resolves branches (pc_src).
//   - Registers results into the MEM/WB stage for writeback.

---
 rtl/mem_stage_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of a 5-stage MIPS pipeline with a req/ack data-memory port.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles without dmem_ack.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [31:0] pc_branch_in,
  input  logic [4:0]  write_reg_in,
  input  logic        zero_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        branch_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_branch_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        bus_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_r;
  logic        mem_op_s;
  logic        timeout_s;
  logic        done_s;
  logic        stall_s;

  // request latched on entry to WAIT; upstream may change freely afterwards
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;
  logic [4:0]  wreg_lat_r;
  logic        m2r_lat_r;
  logic        rw_lat_r;

  logic        req_r;
  logic [31:0] read_data_r;
  logic [31:0] alu_out_r;
  logic [4:0]  wreg_out_r;
  logic        m2r_out_r;
  logic        rw_out_r;

  if (2 ** CNT_W <= TIMEOUT) begin : g_bad_cnt_w
    $error("mem_stage_ctrl: CNT_W too narrow for TIMEOUT");
  end

  assign mem_op_s = mem_read_in | mem_write_in;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_r;
  logic             bus_error_r;

  // timeout fires on the TIMEOUT-th consecutive WAIT cycle without ack
  assign timeout_s = (state_r == WAIT) && !dmem_ack && (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // wait-cycle counter and one-cycle bus error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r  <= '0;
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= timeout_s;
      if ((state_r == WAIT) && !dmem_ack && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  assign bus_error = bus_error_r;
`else
  assign timeout_s = 1'b0;
  assign bus_error = 1'b0;
`endif

  assign done_s = (state_r == WAIT) && (dmem_ack || timeout_s);

  // stall upstream from the issue cycle until the access completes
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = mem_op_s;
      WAIT:    stall_s = !(dmem_ack || timeout_s);
      default: stall_s = 1'b0;
    endcase
  end

  assign stall         = stall_s;
  assign pc_src        = branch_in & zero_in & ~stall_s;
  assign pc_branch_out = stall_s ? 32'h0000_0000 : pc_branch_in;

  // access FSM, request latch and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      we_r        <= 1'b0;
      wreg_lat_r  <= 5'd0;
      m2r_lat_r   <= 1'b0;
      rw_lat_r    <= 1'b0;
      read_data_r <= 32'h0000_0000;
      alu_out_r   <= 32'h0000_0000;
      wreg_out_r  <= 5'd0;
      m2r_out_r   <= 1'b0;
      rw_out_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            addr_r     <= alu_result_in;
            wdata_r    <= write_data_in;
            we_r       <= mem_write_in;
            wreg_lat_r <= write_reg_in;
            m2r_lat_r  <= mem_to_reg_in;
            rw_lat_r   <= reg_write_in;
            req_r      <= 1'b1;
            rw_out_r   <= 1'b0;
            state_r    <= WAIT;
          end else begin
            read_data_r <= 32'h0000_0000;
            alu_out_r   <= alu_result_in;
            wreg_out_r  <= write_reg_in;
            m2r_out_r   <= mem_to_reg_in;
            rw_out_r    <= reg_write_in;
            req_r       <= 1'b0;
            state_r     <= IDLE;
          end
        end
        WAIT: begin
          if (done_s) begin
            // stores and aborted loads write back zero data
            read_data_r <= (we_r || timeout_s) ? 32'h0000_0000 : dmem_rdata;
            alu_out_r   <= addr_r;
            wreg_out_r  <= wreg_lat_r;
            m2r_out_r   <= m2r_lat_r;
            rw_out_r    <= rw_lat_r & ~timeout_s;
            req_r       <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rw_out_r <= 1'b0;
            req_r    <= 1'b1;
            state_r  <= WAIT;
          end
        end
        default: begin
          req_r    <= 1'b0;
          rw_out_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req       = req_r;
  assign dmem_we        = we_r;
  assign dmem_addr      = addr_r;
  assign dmem_wdata     = wdata_r;
  assign read_data_out  = read_data_r;
  assign alu_result_out = alu_out_r;
  assign write_reg_out  = wreg_out_r;
  assign mem_to_reg_out = m2r_out_r;
  assign reg_write_out  = rw_out_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, directed multi-cycle sequences,
// and a randomized run against a transaction-level model (TIMEOUT=4 for the MEM_TIMEOUT_EN build).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, write_data_in, pc_branch_in, dmem_rdata;
  logic [4:0]  write_reg_in;
  logic        zero_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, branch_in, dmem_ack;
  logic        dmem_req, dmem_we, stall, pc_src, mem_to_reg_out, reg_write_out, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_out, read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  int n_pass = 0;
  int n_total = 0;

  mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .pc_branch_in(pc_branch_in),
    .write_reg_in(write_reg_in), .zero_in(zero_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .branch_in(branch_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .pc_src(pc_src), .pc_branch_out(pc_branch_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu; logic [4:0] wreg; logic br; logic zero; logic [31:0] pcb; logic m2r; logic rw;
    logic exp_pc_src; logic [31:0] exp_pcb; logic [31:0] exp_alu; logic [4:0] exp_wreg; logic exp_m2r; logic exp_rw;
  } vec_t;

  typedef struct {
    logic [31:0] alu; logic [31:0] wd; logic [31:0] pcb; logic [4:0] wreg;
    logic zero; logic rd; logic wr; logic m2r; logic rw; logic br;
  } ins_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pcb,
                       input logic [4:0] wreg, input logic zero, input logic rd, input logic wr,
                       input logic m2r, input logic rw, input logic br);
    alu_result_in = alu; write_data_in = wd; pc_branch_in = pcb; write_reg_in = wreg;
    zero_in = zero; mem_read_in = rd; mem_write_in = wr; mem_to_reg_in = m2r;
    reg_write_in = rw; branch_in = br;
  endtask

  task automatic drive_nop();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // one memory op: ack after nwait ack-less WAIT cycles, inputs scrambled while waiting
  task automatic mem_seq(input string tag, input logic rd_op, input logic wr_op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] wreg,
                         input logic rw, input int nwait, input int exp_stall,
                         input logic [31:0] exp_rd, input int exp_rw_pulses);
    int st_cnt = 0;
    int rw_cnt = 0;
    logic req_ok = 1'b1;
    for (int c = 0; c <= nwait + 1; c++) begin
      @(negedge clk);
      if (c == 0) drive(addr, wdata, 32'h0, wreg, 1'b0, rd_op, wr_op, rd_op, rw, 1'b0);
      else drive(~addr, ~wdata, 32'h0, ~wreg, 1'b1, 1'b1, ~wr_op, 1'b0, ~rw, 1'b0);
      dmem_ack   = (c == nwait + 1);
      dmem_rdata = dmem_ack ? rdata : 32'h0BAD_0BAD;
      #1;
      st_cnt += int'(stall);
      if (c >= 1) begin
        if (!(dmem_req === 1'b1 && dmem_addr === addr && dmem_we === wr_op &&
              (!wr_op || dmem_wdata === wdata))) req_ok = 1'b0;
        if (reg_write_out) rw_cnt++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_nop();
      dmem_ack = 1'b0;
      #1;
      st_cnt += int'(stall);
      if (reg_write_out) rw_cnt++;
      if (c == 0) begin
        chk({tag, "_rdata"}, read_data_out, exp_rd);
        chk({tag, "_alu_out"}, alu_result_out, addr);
        chk({tag, "_wreg_out"}, 32'(write_reg_out), 32'(wreg));
        chk({tag, "_m2r_out"}, 32'(mem_to_reg_out), 32'(rd_op));
        chk({tag, "_req_low"}, 32'(dmem_req), 32'h0);
      end
    end
    chk({tag, "_stall_cycles"}, 32'(st_cnt), 32'(exp_stall));
    chk({tag, "_rw_pulses"}, 32'(rw_cnt), 32'(exp_rw_pulses));
    chk({tag, "_req_stable"}, 32'(req_ok), 32'h1);
  endtask

  vec_t tbl[6];
  ins_t cur;
  int k, nw, sel;
  logic is_mem, req_e, stall_e, retired;
  logic [31:0] mrd, e_alu, e_rd;
  logic [4:0] e_wreg;
  logic e_m2r, e_rw;

  initial begin
    tbl[0] = '{32'h0000_1234, 5'd5,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_1234, 5'd5,  1'b0, 1'b1};
    tbl[1] = '{32'h0000_0000, 5'd0,  1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
    tbl[2] = '{32'h0000_0000, 5'd0,  1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hABCD_0000, 1'b1, 1'b1, 1'b0, 32'hABCD_0000, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1};
    tbl[4] = '{32'h0000_0000, 5'd1,  1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 5'd1,  1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 5'd17, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h8000_0000, 5'd17, 1'b0, 1'b1};

    rst = 1'b1;
    drive_nop();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", 32'(dmem_req), 32'h0);
    chk("reset_rw_out", 32'(reg_write_out), 32'h0);
    chk("reset_alu_out", alu_result_out, 32'h0);
    chk("reset_bus_error", 32'(bus_error), 32'h0);
    rst = 1'b0;

    // non-memory vectors: one-cycle latency, combinational branch outputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(tbl[i].alu, 32'h0, tbl[i].pcb, tbl[i].wreg, tbl[i].zero, 1'b0, 1'b0, tbl[i].m2r, tbl[i].rw, tbl[i].br);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'h0);
      chk($sformatf("vec%0d_pc_src", i), 32'(pc_src), 32'(tbl[i].exp_pc_src));
      chk($sformatf("vec%0d_pcb_out", i), pc_branch_out, tbl[i].exp_pcb);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_alu_out", i), alu_result_out, tbl[i].exp_alu);
      chk($sformatf("vec%0d_wreg_out", i), 32'(write_reg_out), 32'(tbl[i].exp_wreg));
      chk($sformatf("vec%0d_m2r_out", i), 32'(mem_to_reg_out), 32'(tbl[i].exp_m2r));
      chk($sformatf("vec%0d_rw_out", i), 32'(reg_write_out), 32'(tbl[i].exp_rw));
      chk($sformatf("vec%0d_rdata", i), read_data_out, 32'h0);
    end

    mem_seq("load3",  1'b1, 1'b0, 32'h0000_0040, 32'h0000_1111, 32'hDEAD_BEEF, 5'd7, 1'b1, 3, 4, 32'hDEAD_BEEF, 1);
    mem_seq("store1", 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_0001, 32'h5555_AAAA, 5'd0, 1'b0, 1, 2, 32'h0, 0);
    mem_seq("load0",  1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_F00D, 5'd2, 1'b1, 0, 1, 32'h0000_F00D, 1);
    mem_seq("rdwr2",  1'b1, 1'b1, 32'h0000_000C, 32'h0000_0077, 32'h0000_0099, 5'd4, 1'b1, 2, 3, 32'h0, 1);

    // reset while waiting for ack aborts the access with no writeback
    @(negedge clk);
    drive(32'h0000_0044, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      drive_nop();
    end
    #1;
    chk("rst_wait_req_before", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'h0);
    chk("rst_wait_stall", 32'(stall), 32'h0);
    chk("rst_wait_rw_out", 32'(reg_write_out), 32'h0);
    chk("rst_wait_alu_out", alu_result_out, 32'h0);
    chk("rst_wait_rdata", read_data_out, 32'h0);
    drive(32'h0000_0055, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    drive_nop();
    dmem_ack = 1'b0;
    #1;
    chk("post_rst_alu_out", alu_result_out, 32'h0000_0055);
    chk("post_rst_rw_out", 32'(reg_write_out), 32'h1);
    chk("post_rst_rdata", read_data_out, 32'h0);
    chk("post_rst_req", 32'(dmem_req), 32'h0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    drive(32'h0000_0200, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("to_issue_stall", 32'(stall), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive_nop();
      #1;
      chk($sformatf("to_wait%0d_stall", c), 32'(stall), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("to_wait%0d_bus_error", c), 32'(bus_error), 32'h0);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFEED_FACE;
    #1;
    chk("to_bus_error", 32'(bus_error), 32'h1);
    chk("to_req", 32'(dmem_req), 32'h0);
    chk("to_rw_out", 32'(reg_write_out), 32'h0);
    chk("to_rdata", read_data_out, 32'h0);
    chk("to_alu_out", alu_result_out, 32'h0000_0200);
    chk("to_late_ack_stall", 32'(stall), 32'h0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("to_pulse_end", 32'(bus_error), 32'h0);
    chk("to_late_ack_rw", 32'(reg_write_out), 32'h0);
    chk("to_late_ack_req", 32'(dmem_req), 32'h0);
`endif

    // randomized run against a per-instruction model; MEM/WB currently holds a retired nop
    @(negedge clk);
    drive_nop();
    e_alu = 32'h0; e_wreg = 5'd0; e_m2r = 1'b0; e_rw = 1'b0; e_rd = 32'h0;
    retired = 1'b1;
    k = 0; nw = 0; mrd = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      chk("rnd_alu_out", alu_result_out, e_alu);
      chk("rnd_wreg_out", 32'(write_reg_out), 32'(e_wreg));
      chk("rnd_m2r_out", 32'(mem_to_reg_out), 32'(e_m2r));
      chk("rnd_rdata", read_data_out, e_rd);
      chk("rnd_rw_out", 32'(reg_write_out), 32'(retired & e_rw));
      if (k == 0) begin
        sel = $urandom_range(0, 19);
        cur.alu = $urandom; cur.wd = $urandom; cur.pcb = $urandom; cur.wreg = 5'($urandom);
        cur.zero = 1'($urandom); cur.m2r = 1'($urandom); cur.rw = 1'($urandom);
        cur.rd = (sel >= 8 && sel < 13) || sel == 19;
        cur.wr = (sel >= 13 && sel < 17) || sel == 19;
        cur.br = (sel >= 17 && sel < 19);
        nw = $urandom_range(0, 3);
        mrd = $urandom;
        drive(cur.alu, cur.wd, cur.pcb, cur.wreg, cur.zero, cur.rd, cur.wr, cur.m2r, cur.rw, cur.br);
      end else begin
        drive($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      is_mem  = cur.rd | cur.wr;
      req_e   = is_mem && (k >= 1);
      stall_e = is_mem && (k <= nw);
      dmem_ack   = req_e ? (k - 1 == nw) : ($urandom_range(0, 3) == 0);
      dmem_rdata = (req_e && dmem_ack) ? mrd : $urandom;
      #1;
      chk("rnd_stall", 32'(stall), 32'(stall_e));
      chk("rnd_req", 32'(dmem_req), 32'(req_e));
      chk("rnd_pc_src", 32'(pc_src), 32'(branch_in & zero_in & ~stall_e));
      chk("rnd_pcb_out", pc_branch_out, stall_e ? 32'h0 : pc_branch_in);
      chk("rnd_bus_error", 32'(bus_error), 32'h0);
      if (req_e) begin
        chk("rnd_addr", dmem_addr, cur.alu);
        chk("rnd_we", 32'(dmem_we), 32'(cur.wr));
        if (cur.wr) chk("rnd_wdata", dmem_wdata, cur.wd);
      end
      if (!stall_e) begin
        e_alu = cur.alu; e_wreg = cur.wreg; e_m2r = cur.m2r; e_rw = cur.rw;
        e_rd = (is_mem && !cur.wr) ? mrd : 32'h0;
        retired = 1'b1;
        k = 0;
      end else begin
        retired = 1'b0;
        k++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
